// File: rtl/fp32_pkg.sv
// fp32_pkg: shared binary32 constants and divider FSM states
package fp32_pkg;
  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int BIAS = 127;
  localparam logic [31:0] QNAN = 32'h7FC00000;
  localparam int DIV_ITER = 27;
  typedef enum logic [2:0] {IDLE, PREP, DIV, ROUND, DONE} state_t;
endpackage

// File: rtl/fp32_lzc.sv
// fp32_lzc: 24-bit leading-zero counter, returns 24 for an all-zero input
module fp32_lzc (
  input  logic [23:0] i_d,
  output logic [4:0]  o_cnt
);
  always_comb begin
    o_cnt = 5'd24;
    for (int i = 0; i < 24; i++) if (i_d[i]) o_cnt = 5'(23 - i);
  end
endmodule

// File: rtl/fp32_divider_seq.sv
// fp32_divider_seq: iterative binary32 divider, radix-2 restoring, round-to-nearest-even
module fp32_divider_seq
  import fp32_pkg::*;
#(
  parameter bit FLUSH_SUBNORM = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] C,
  output logic        dz_flag,
  output logic        nv_flag
);
  state_t       r_state;
  logic [31:0]  r_a, r_b, r_c;
  logic         r_sign, r_spec, r_ov, r_dz, r_nv;
  logic [9:0]   r_e;
  logic [23:0]  r_mb;
  logic [25:0]  r_rem;
  logic [26:0]  r_q;
  logic [4:0]   r_cnt;
  logic [7:0]   w_xa, w_xb;
  logic [22:0]  w_fa, w_fb;
  logic         w_za, w_zb, w_ia, w_ib, w_na, w_nb, w_s, w_nv, w_dz, w_spec;
  logic [31:0]  w_spec_c;
  logic [4:0]   w_lza, w_lzb;
  logic [23:0]  w_ma, w_mb;
  logic [9:0]   w_ea, w_eb;
  logic         w_ge;
  logic [25:0]  w_sub;
  logic [26:0]  w_q1, w_qs;
  logic [9:0]   w_e1, w_shf;
  logic [4:0]   w_sh;
  logic         w_den, w_lost, w_st, w_rnd;
  logic [24:0]  w_m25;
  logic [32:0]  w_sum;
  logic [31:0]  w_res;
  assign in_ready = (r_state == IDLE);
  assign out_valid = r_ov;
  assign C = r_c;
  assign dz_flag = r_dz;
  assign nv_flag = r_nv;
  assign w_xa = r_a[30:23];
  assign w_xb = r_b[30:23];
  assign w_fa = r_a[22:0];
  assign w_fb = r_b[22:0];
  assign w_za = (w_xa == 8'd0) && (w_fa == 23'd0 || FLUSH_SUBNORM);
  assign w_zb = (w_xb == 8'd0) && (w_fb == 23'd0 || FLUSH_SUBNORM);
  assign w_ia = (&w_xa) && (w_fa == 23'd0);
  assign w_ib = (&w_xb) && (w_fb == 23'd0);
  assign w_na = (&w_xa) && (w_fa != 23'd0);
  assign w_nb = (&w_xb) && (w_fb != 23'd0);
  assign w_s = r_a[31] ^ r_b[31];
  assign w_nv = w_na | w_nb | (w_za & w_zb) | (w_ia & w_ib);
  assign w_dz = ~w_nv & ~w_ia & w_zb;
  assign w_spec = w_nv | w_ia | w_ib | w_za | w_zb;
  assign w_spec_c = w_nv ? QNAN : (w_ia | w_zb) ? {w_s, 8'hFF, 23'd0} : {w_s, 31'd0};
  fp32_lzc u_lzc_a (.i_d({|w_xa, w_fa}), .o_cnt(w_lza));
  fp32_lzc u_lzc_b (.i_d({|w_xb, w_fb}), .o_cnt(w_lzb));
  // Subnormals are renormalised so both significands enter the divider in [1,2)
  assign w_ma = {|w_xa, w_fa} << w_lza;
  assign w_mb = {|w_xb, w_fb} << w_lzb;
  assign w_ea = (w_xa == 8'd0) ? 10'd1 - 10'(w_lza) : 10'(w_xa);
  assign w_eb = (w_xb == 8'd0) ? 10'd1 - 10'(w_lzb) : 10'(w_xb);
  assign w_ge = r_rem >= {2'b0, r_mb};
  assign w_sub = w_ge ? r_rem - {2'b0, r_mb} : r_rem;
  assign w_q1 = r_q[26] ? r_q : r_q << 1;
  assign w_e1 = r_q[26] ? r_e : r_e - 10'd1;
  assign w_den = $signed(w_e1) <= 0;
  assign w_shf = 10'd1 - w_e1;
  assign w_sh = !w_den ? 5'd0 : (w_shf > 10'd26) ? 5'd26 : w_shf[4:0];
  assign w_qs = w_q1 >> w_sh;
  assign w_lost = |(w_q1 & ~({27{1'b1}} << w_sh));
  assign w_st = (r_rem != 26'd0) | w_lost | (|w_qs[1:0]);
  assign w_rnd = w_qs[2] & (w_qs[3] | w_st);
  assign w_m25 = {1'b0, w_qs[26:3]} + 25'(w_rnd);
  // Exponent minus one plus the significand with hidden bit lets a rounding carry bump the exponent
  assign w_sum = {w_den ? 10'd0 : w_e1 - 10'd1, 23'd0} + 33'(w_m25);
  assign w_res = (w_sum[32:23] >= 10'd255) ? {r_sign, 8'hFF, 23'd0} :
                 (FLUSH_SUBNORM && w_sum[30:23] == 8'd0) ? {r_sign, 31'd0} : {r_sign, w_sum[30:0]};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_a <= '0;
      r_b <= '0;
      r_c <= '0;
      r_sign <= 1'b0;
      r_spec <= 1'b0;
      r_ov <= 1'b0;
      r_dz <= 1'b0;
      r_nv <= 1'b0;
      r_e <= '0;
      r_mb <= '0;
      r_rem <= '0;
      r_q <= '0;
      r_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: if (in_valid) begin
          r_a <= A;
          r_b <= B;
          r_state <= PREP;
        end
        PREP: begin
          r_sign <= w_s;
          r_spec <= w_spec;
          r_c <= w_spec_c;
          r_dz <= w_dz;
          r_nv <= w_nv;
          r_rem <= {2'b0, w_ma};
          r_mb <= w_mb;
          r_e <= w_ea - w_eb + 10'(BIAS);
          r_q <= '0;
          r_cnt <= '0;
          r_state <= w_spec ? ROUND : DIV;
        end
        DIV: begin
          r_rem <= {w_sub[24:0], 1'b0};
          r_q <= {r_q[25:0], w_ge};
          r_cnt <= r_cnt + 5'd1;
          if (r_cnt == 5'(DIV_ITER - 1)) r_state <= ROUND;
        end
        ROUND: begin
          if (!r_spec) r_c <= w_res;
          r_ov <= 1'b1;
          r_state <= DONE;
        end
        DONE: if (out_ready) begin
          r_ov <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule
